// File: rtl/demux8_16bit_regfile.sv
// demux8_16bit_regfile: 3-to-8 write demux into eight byte-enabled registers
// with synchronous bulk clear, per-register written flags and a write acknowledge.
module dec3to8 (
    input  logic       en,
    input  logic [2:0] a,
    output logic [7:0] y
);
    logic [2:0] an;
    assign an = ~a;
    for (genvar i = 0; i < 8; i++) begin : g_and
        localparam logic [2:0] K = 3'(i);
        assign y[i] = en & (K[0] ? a[0] : an[0]) & (K[1] ? a[1] : an[1]) & (K[2] ? a[2] : an[2]);
    end
endmodule

module mux2 #(
    parameter int W = 1
) (
    input  logic         s,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = s ? b : a;
endmodule

module dff_ar (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 1'b0;
        else     q <= d;
    end
endmodule

module demux8_16bit_regfile #(
    parameter int             WIDTH   = 16,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [2:0]       wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [1:0]       wr_be,
    input  logic             clr,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [WIDTH-1:0] out5,
    output logic [WIDTH-1:0] out6,
    output logic [WIDTH-1:0] out7,
    output logic [7:0]       vld,
    output logic             wr_ack
);
    logic [7:0]            sel;
    logic [7:0][WIDTH-1:0] reg_q, reg_d, base, ld;
    logic [7:0]            vld_q, vld_d;
    logic                  wr_ack_q, wr_ack_d;

    dec3to8 u_dec (.en(wr_en), .a(wr_sel), .y(sel));

    // Clear picks the base value first; a load then overrides only enabled bytes.
    for (genvar r = 0; r < 8; r++) begin : g_reg
        mux2 #(.W(WIDTH)) u_clr (.s(clr), .a(reg_q[r]), .b(CLR_VAL), .y(base[r]));
        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            assign ld[r][b] = sel[r] & ((b >= WIDTH / 2) ? wr_be[1] : wr_be[0]);
            mux2 #(.W(1)) u_ld (.s(ld[r][b]), .a(base[r][b]), .b(wr_data[b]), .y(reg_d[r][b]));
            dff_ar u_ff (.clk(clk), .rst(rst), .d(reg_d[r][b]), .q(reg_q[r][b]));
        end
    end

    always_comb begin
        vld_d    = (clr ? 8'h00 : vld_q) | ((wr_be != 2'b00) ? sel : 8'h00);
        wr_ack_d = wr_en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q    <= 8'h00;
            wr_ack_q <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            wr_ack_q <= wr_ack_d;
        end
    end

    assign out0   = reg_q[0];
    assign out1   = reg_q[1];
    assign out2   = reg_q[2];
    assign out3   = reg_q[3];
    assign out4   = reg_q[4];
    assign out5   = reg_q[5];
    assign out6   = reg_q[6];
    assign out7   = reg_q[7];
    assign vld    = vld_q;
    assign wr_ack = wr_ack_q;
endmodule

// File: doc/demux8_16bit_regfile.md
Name: demux8_16bit_regfile

Overview:
- Write-side counterpart of the 8:1 16-bit read multiplexer.
- Decodes a 3-bit select and steers one 16-bit write word into one of eight 16-bit storage registers.
- Exposes all eight registers in parallel as out0..out7. These buses feed the 8:1 mux read path directly.
- Adds byte enables, a synchronous bulk clear, per-register "written" flags and a one-cycle write acknowledge.

Parameters:
- WIDTH, 16, data width per register. Must be even; split into a low half and a high half for byte enables.
- CLR_VAL, 16'h0000, value loaded by the synchronous clear (clr).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write request, sampled on the rising clk edge.
- wr_sel  input  3  destination register index, 0..7.
- wr_data  input  WIDTH  write data.
- wr_be  input  2  byte enables: bit0 = [7:0], bit1 = [15:8].
- clr  input  1  synchronous clear of all registers and flags.
- out0..out7  output  WIDTH each  current register contents.
- vld  output  8  vld[i]=1 means register i has been written since the last reset or clear.
- wr_ack  output  1  one-cycle pulse confirming an accepted write.

Behaviour:
- Reset is asynchronous and active-high.
  - On rst=1, immediately and without clk: out0..out7 = 0, vld = 8'h00, wr_ack = 0.
  - Holds while rst=1, including if asserted mid-write; a write in flight is lost.
  - First edge with rst=0 operates normally.
- Decode: 3-to-8 one-hot decoder on wr_sel, gated by wr_en. At most one register is targeted per cycle.
- Write, on the edge where wr_en=1:
  - Register wr_sel low byte <= wr_data[7:0] if wr_be[0].
  - High byte <= wr_data[15:8] if wr_be[1].
  - Unselected registers hold.
- Latency: new data is visible on outN one cycle after the sampling edge (registered; no combinational write-through).
- vld: vld[wr_sel] <= 1 on a write with wr_be != 2'b00. A write with wr_be=00 changes neither data nor vld.
- wr_ack: registered.
  - wr_ack = 1 in the cycle after any edge with wr_en=1, regardless of wr_be.
  - Otherwise 0.
  - Back-to-back writes give wr_ack high continuously.
  - No backpressure: a write is accepted on every cycle wr_en=1.
- clr, on the edge where clr=1:
  - All registers <= CLR_VAL.
  - vld <= 0.
- clr and wr_en on the same edge:
  - The clear applies to all registers, then the write overrides the selected register's enabled bytes.
  - Disabled bytes of that register take CLR_VAL.
  - vld = one-hot of wr_sel if wr_be != 0, else 0.
  - wr_ack pulses.
- Consecutive writes to the same index: last write wins, byte-wise.
- wr_sel is fully decoded (all 8 codes valid); X on wr_sel with wr_en=1 is illegal.
- Implementation is structural, in the same style as the mux path:
  - decoder from the existing gate primitives;
  - per-bit D flip-flop with async reset;
  - per-bit 2:1 mux for hold/load;
  - a higher-level mux for the clear path.

Test Plan:
- Reset check: assert rst mid-cycle with registers holding 16'hA5A5 → all outN = 0, vld = 00, wr_ack = 0 immediately, before the next clk edge.
- Full sweep: write wr_sel = i, wr_data = 16'h1111*i (i = 1..7; i = 0 writes 16'hFFFF), wr_be = 11 on consecutive cycles.
  - Each outN updates exactly one cycle after its write.
  - Other registers are unchanged.
  - vld ends at 8'hFF.
  - wr_ack is high for 8 consecutive cycles, then drops.
- Byte enables: reg3 = 16'h1234.
  - Write 16'hABCD with be = 01 → out3 = 16'h12CD.
  - Then 16'h5678 with be = 10 → out3 = 16'h56CD.
  - Then be = 00 with 16'hFFFF → out3 unchanged, wr_ack = 1.
- Clear: all registers written, then clr = 1 for one edge → all outN = 0000, vld = 00, wr_ack = 0.
- Simultaneous: clr = 1, wr_en = 1, wr_sel = 5, wr_data = 16'hBEEF, be = 10 on the same edge.
  - out5 = 16'hBE00; all other registers 0.
  - vld = 8'h20; wr_ack = 1 in the next cycle.
- End-to-end: connect out0..out7 to the 8:1 mux, write distinct values, sweep the mux select 0..7 → the mux output matches the value written at the same index.
